// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side stream adapters (read-side packer,
// write-side unpacker): a constant-safe clog2 and default stream widths.
package fifo_pkg;

   // Default beat width of the dual-FIFO path.
   localparam int FIFO_DSIZE = 8;
   // Default number of beats per packed stream word.
   localparam int PACK_WORDS = 4;

   // Ceiling log2, usable in parameter and localparam expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) begin
            r = r + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Valid/ready holding register for a packed stream word plus its keep mask.
// A load always wins and sets valid. Without a load, a handshake clears
// valid. Data and keep are held after the handshake and are not cleared.
module packer_out_reg #(
   parameter int DW = 32,
   parameter int KW = 4
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic [KW-1:0] load_keep,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [KW-1:0] out_keep
);

   logic          out_valid_q;
   logic [DW-1:0] out_data_q;
   logic [KW-1:0] out_keep_q;

   // Output word register: load takes priority, otherwise drop valid on handshake.
   always_ff @(posedge clk) begin
      if (srst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_data_q  <= load_data;
         out_keep_q  <= load_keep;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;

endmodule

// File: rtl/fifo_rd_word_packer.sv
// Read-side word packer. It pops DSIZE-bit beats from a fall-through FIFO
// and packs WORDS beats into one output word. The first popped beat goes in
// the low bits. The accumulator and the output register give double
// buffering, so a steady stream packs one beat per cycle.
// Optional build macro PACKER_TIMEOUT_EN enables a partial-word flush after
// TIMEOUT idle cycles.
module fifo_rd_word_packer
   import fifo_pkg::*;
#(
   parameter int DSIZE   = FIFO_DSIZE,
   parameter int WORDS   = PACK_WORDS,
   parameter int TIMEOUT = 16
) (
   input  logic                   rclk,
   input  logic                   rrst,
   input  logic                   rempty,
   input  logic [DSIZE-1:0]       rdata,
   output logic                   rinc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DSIZE*WORDS-1:0] out_data,
   output logic [WORDS-1:0]       out_keep,
   output logic                   busy
);

   localparam int            CW   = clog2(WORDS);
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   logic [CW-1:0]               count_q, count_d;
   logic [WORDS-2:0][DSIZE-1:0] acc_q, acc_d;
   logic                        acc_stall;
   logic                        pop;
   logic                        full_load;
   logic                        flush;
   logic                        load;
   logic [DSIZE*WORDS-1:0]      load_data;
   logic [WORDS-1:0]            load_keep;

   // The last beat of a word stays in the FIFO until the output register can take it.
   assign acc_stall = (count_q == LAST) && out_valid && !out_ready;
   assign rinc      = !rrst && !rempty && !acc_stall;
   assign pop       = rinc;
   assign full_load = pop && (count_q == LAST);

   // Each accumulator slot captures the head beat when the count points at it.
   // The final beat goes straight from rdata to the output register.
   for (genvar gi = 0; gi < WORDS - 1; gi++) begin : g_slot
      assign acc_d[gi] = (pop && (count_q == CW'(gi))) ? rdata : acc_q[gi];
   end

`ifdef PACKER_TIMEOUT_EN
   localparam int            IW        = clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

   logic [IW-1:0]               idle_q, idle_d;
   logic [WORDS-2:0][DSIZE-1:0] flush_acc;
   logic [WORDS-1:0]            flush_keep;

   // A pop in the same cycle wins over a flush, so no beat is stranded.
   assign flush = (count_q != '0) && !pop && (idle_q == IDLE_LAST) && (!out_valid || out_ready);

   // A partial word carries only the filled slots. Upper slots read as zero.
   for (genvar gi = 0; gi < WORDS - 1; gi++) begin : g_flush_slot
      assign flush_acc[gi] = (CW'(gi) < count_q) ? acc_q[gi] : '0;
   end
   for (genvar gi = 0; gi < WORDS; gi++) begin : g_flush_keep
      assign flush_keep[gi] = (CW'(gi) < count_q);
   end

   assign load      = full_load || flush;
   assign load_data = full_load ? {rdata, acc_q} : {{DSIZE{1'b0}}, flush_acc};
   assign load_keep = full_load ? {WORDS{1'b1}} : flush_keep;

   // Idle counter: runs only while a partial word waits with no pops. It saturates at the flush point.
   always_comb begin
      idle_d = idle_q;
      if (pop || (count_q == '0) || flush) begin
         idle_d = '0;
      end else if (idle_q != IDLE_LAST) begin
         idle_d = idle_q + 1'b1;
      end
   end

   // Idle counter register.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic timeout_unused;

   assign timeout_unused = (TIMEOUT > 0);
   assign flush          = 1'b0;
   assign load           = full_load;
   assign load_data      = {rdata, acc_q};
   assign load_keep      = {WORDS{1'b1}};
`endif

   // Beat count wraps explicitly at WORDS-1. It does not rely on a power-of-two overflow.
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (pop) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   // Accumulator and count registers. Reset discards any partial word.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         count_q <= '0;
         acc_q   <= '0;
      end else begin
         count_q <= count_d;
         acc_q   <= acc_d;
      end
   end

   packer_out_reg #(
      .DW (DSIZE * WORDS),
      .KW (WORDS)
   ) u_out_reg (
      .clk       (rclk),
      .srst      (rrst),
      .load      (load),
      .load_data (load_data),
      .load_keep (load_keep),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep)
   );

   assign busy = (count_q != '0) || out_valid;

endmodule

// File: tb/tb_fifo_rd_word_packer.sv
// Testbench for fifo_rd_word_packer. It combines directed scenarios with a
// randomized phase. Both are checked against a queue-based model of the FIFO,
// the partial word and the pending output words.
module tb_fifo_rd_word_packer;

   localparam int DSIZE   = 8;
   localparam int WORDS   = 4;
   localparam int TIMEOUT = 16;

   logic        rclk = 1'b0;
   logic        rrst = 1'b1;
   logic        rempty = 1'b1;
   logic [7:0]  rdata = '0;
   logic        rinc;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        busy;

   always #5 rclk = ~rclk;

   fifo_rd_word_packer #(
      .DSIZE   (DSIZE),
      .WORDS   (WORDS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: FIFO contents, beats of the word being packed, completed words not yet accepted.
   logic [7:0]  fifo_m[$];
   logic [7:0]  acc_m[$];
   logic [31:0] word_m[$];
   logic [3:0]  keep_m[$];
   int          idle_m = 0;
   int          accepted = 0;
   int          pops = 0;
   bit          last_rinc = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack_acc();
      logic [31:0] w;
      w = '0;
      foreach (acc_m[i]) w[i*DSIZE +: DSIZE] = acc_m[i];
      return w;
   endfunction

   // One clock cycle: drive at negedge, check against the model, then advance the model across the next posedge.
   task automatic step(input bit rst, input bit rdy, input bit hold_empty);
      bit exp_rinc;
      bit stall;
      bit was_valid;
      @(negedge rclk);
      rrst      = rst;
      out_ready = rdy;
      rempty    = hold_empty || (fifo_m.size() == 0);
      rdata     = (fifo_m.size() > 0 && !hold_empty) ? fifo_m[0] : 8'($urandom);
      #1;
      was_valid = (word_m.size() > 0);
      stall     = (acc_m.size() == WORDS - 1) && was_valid && !rdy;
      exp_rinc  = !rst && !rempty && !stall;
      last_rinc = rinc;
      check_eq("rinc", rinc, exp_rinc);
      check_eq("out_valid", out_valid, was_valid);
      check_eq("busy", busy, was_valid || (acc_m.size() > 0));
      if (was_valid) begin
         check_eq("out_data", out_data, word_m[0]);
         check_eq("out_keep", out_keep, keep_m[0]);
      end
      $display("cyc rst=%0b rdy=%0b empty=%0b rinc=%0b valid=%0b data=%08h keep=%0h", rst, rdy, rempty, rinc, out_valid, out_data, out_keep);
      if (rst) begin
         acc_m.delete();
         word_m.delete();
         keep_m.delete();
         idle_m = 0;
      end else begin
         if (was_valid && rdy) begin
            void'(word_m.pop_front());
            void'(keep_m.pop_front());
            accepted++;
         end
         if (exp_rinc) begin
            acc_m.push_back(fifo_m.pop_front());
            pops++;
            idle_m = 0;
            if (acc_m.size() == WORDS) begin
               word_m.push_back(pack_acc());
               keep_m.push_back(4'hF);
               acc_m.delete();
            end
         end
`ifdef PACKER_TIMEOUT_EN
         else if (acc_m.size() > 0) begin
            idle_m++;
            if (idle_m >= TIMEOUT && word_m.size() == 0) begin
               word_m.push_back(pack_acc());
               keep_m.push_back(4'((1 << acc_m.size()) - 1));
               acc_m.delete();
               idle_m = 0;
            end
         end else begin
            idle_m = 0;
         end
`endif
      end
   endtask

   task automatic after_edge();
      @(posedge rclk);
      #1;
   endtask

   initial begin
      logic [7:0] b[8];
      int acc0;
      int pop0;
      int run;

      // Reset state
      step(1, 1, 0);
      step(1, 1, 0);
      after_edge();
      check_eq("reset_valid", out_valid, 1'b0);
      check_eq("reset_data", out_data, 32'h0);
      check_eq("reset_keep", out_keep, 4'h0);
      check_eq("reset_busy", busy, 1'b0);

      // 1) single word 11,22,33,44
      fifo_m = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      after_edge();
      check_eq("t1_valid", out_valid, 1'b1);
      check_eq("t1_data", out_data, 32'h44332211);
      check_eq("t1_keep", out_keep, 4'hF);
      step(0, 1, 0);

      // 2) eight streamed beats: rinc high every cycle, two words out
      for (int i = 0; i < 8; i++) fifo_m.push_back(8'($urandom));
      acc0 = accepted;
      run  = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0);
         if (last_rinc) run++;
      end
      step(0, 1, 0);
      check_eq("t2_rinc_run", 32'(run), 32'd8);
      check_eq("t2_words", 32'(accepted - acc0), 32'd2);

      // 3) stall with a word pending
      step(1, 1, 0);
      for (int i = 0; i < 4; i++) fifo_m.push_back(8'($urandom));
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         b[i] = 8'($urandom);
         fifo_m.push_back(b[i]);
      end
      pop0 = pops;
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      check_eq("t3_pops", 32'(pops - pop0), 32'd3);
      check_eq("t3_stall_rinc", last_rinc, 1'b0);
      step(0, 1, 0);
      check_eq("t3_release_rinc", last_rinc, 1'b1);
      after_edge();
      check_eq("t3_valid", out_valid, 1'b1);
      check_eq("t3_data", out_data, {b[3], b[2], b[1], b[0]});
      step(0, 1, 0);

      // 4) reset mid-word discards partial word, FIFO beats survive
      step(1, 1, 0);
      for (int i = 0; i < 6; i++) begin
         b[i] = 8'($urandom);
         fifo_m.push_back(b[i]);
      end
      step(0, 1, 0);
      step(0, 1, 0);
      step(1, 1, 0);
      after_edge();
      check_eq("t4_valid", out_valid, 1'b0);
      check_eq("t4_data", out_data, 32'h0);
      check_eq("t4_keep", out_keep, 4'h0);
      check_eq("t4_busy", busy, 1'b0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      after_edge();
      check_eq("t4_word", out_data, {b[5], b[4], b[3], b[2]});
      step(0, 1, 0);

`ifdef PACKER_TIMEOUT_EN
      // 5) timeout flush of AA,BB
      step(1, 1, 0);
      fifo_m = '{8'hAA, 8'hBB};
      step(0, 1, 0);
      step(0, 1, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 0);
      after_edge();
      check_eq("t5_valid", out_valid, 1'b1);
      check_eq("t5_data", out_data, 32'h0000BBAA);
      check_eq("t5_keep", out_keep, 4'h3);
      step(0, 1, 0);

      // 6) beat arriving in idle cycle 15 prevents the flush
      step(1, 1, 0);
      fifo_m = '{8'hAA, 8'hBB};
      step(0, 1, 0);
      step(0, 1, 0);
      for (int i = 0; i < 14; i++) step(0, 1, 0);
      fifo_m.push_back(8'hCC);
      step(0, 1, 0);
      after_edge();
      check_eq("t6_no_flush", out_valid, 1'b0);
      check_eq("t6_busy", busy, 1'b1);
      fifo_m.push_back(8'hDD);
      step(0, 1, 0);
      after_edge();
      check_eq("t6_word", out_data, 32'hDDCCBBAA);
      step(0, 1, 0);
`endif

      // Randomized traffic
      step(1, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         if (fifo_m.size() < 16 && $urandom_range(0, 99) < 55) fifo_m.push_back(8'($urandom));
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 20));
      end
      for (int i = 0; i < 40; i++) step(0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
